// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA raster timing bundle shared by every display pipeline stage
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hblnk;
   logic        vblnk;
   logic        hsync;
   logic        vsync;

   modport out    (output hcount, vcount, hblnk, vblnk, hsync, vsync);
   modport in     (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
   modport master (output hcount, vcount, hblnk, vblnk, hsync, vsync);
   modport slave  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster timing generator (optional VGA_FRAME_CNT_EN frame tick/counter)
module vga_timing_gen #(
   parameter int H_ACTIVE  = 800,
   parameter int H_FP      = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BP      = 88,
   parameter int V_ACTIVE  = 600,
   parameter int V_FP      = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BP      = 23,
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
`ifdef VGA_FRAME_CNT_EN
   vga_if.out          vga_out,
   output logic        frame_tick,
   output logic [15:0] frame_cnt
`else
   vga_if.out          vga_out
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Geometry must fit the 11-bit counters.
   if (H_TOTAL > 2048 || H_TOTAL < 1) begin : g_h_total_check
      $error("vga_timing_gen: H_TOTAL must be in 1..2048");
   end
   if (V_TOTAL > 2048 || V_TOTAL < 1) begin : g_v_total_check
      $error("vga_timing_gen: V_TOTAL must be in 1..2048");
   end

   localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
   // Decode thresholds are one bit wider so an active width of 2048 does not alias to 0.
   localparam logic [11:0] H_BLNK_START = 12'(H_ACTIVE);
   localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] V_BLNK_START = 12'(V_ACTIVE);
   localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] r_hcount;
   logic [10:0] r_vcount;
   logic        r_hblnk;
   logic        r_vblnk;
   logic        r_hsync;
   logic        r_vsync;

   logic        w_h_wrap;
   logic        w_v_wrap;
   logic [10:0] w_hcount_next;
   logic [10:0] w_vcount_next;
   logic [11:0] w_h_ext;
   logic [11:0] w_v_ext;
   logic        w_hblnk_next;
   logic        w_vblnk_next;
   logic        w_hsync_next;
   logic        w_vsync_next;

   // Next raster position and its decoded blank/sync levels, so counts and levels register together.
   always_comb begin
      w_h_wrap      = (r_hcount == H_LAST);
      w_v_wrap      = (r_vcount == V_LAST);
      w_hcount_next = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
      w_vcount_next = r_vcount;
      if (w_h_wrap) begin
         w_vcount_next = w_v_wrap ? 11'd0 : r_vcount + 11'd1;
      end
      w_h_ext      = {1'b0, w_hcount_next};
      w_v_ext      = {1'b0, w_vcount_next};
      w_hblnk_next = (w_h_ext >= H_BLNK_START);
      w_vblnk_next = (w_v_ext >= V_BLNK_START);
      w_hsync_next = ((w_h_ext >= H_SYNC_START) && (w_h_ext < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
      w_vsync_next = ((w_v_ext >= V_SYNC_START) && (w_v_ext < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
   end

   // Raster state register; reset parks at (0,0) with blanks low and syncs inactive.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hcount <= 11'd0;
         r_vcount <= 11'd0;
         r_hblnk  <= 1'b0;
         r_vblnk  <= 1'b0;
         r_hsync  <= ~HSYNC_POL;
         r_vsync  <= ~VSYNC_POL;
      end else begin
         r_hcount <= w_hcount_next;
         r_vcount <= w_vcount_next;
         r_hblnk  <= w_hblnk_next;
         r_vblnk  <= w_vblnk_next;
         r_hsync  <= w_hsync_next;
         r_vsync  <= w_vsync_next;
      end
   end

   assign vga_out.hcount = r_hcount;
   assign vga_out.vcount = r_vcount;
   assign vga_out.hblnk  = r_hblnk;
   assign vga_out.vblnk  = r_vblnk;
   assign vga_out.hsync  = r_hsync;
   assign vga_out.vsync  = r_vsync;

`ifdef VGA_FRAME_CNT_EN
   logic        r_frame_tick;
   logic [15:0] r_frame_cnt;

   // Tick and count only on a real wrap from the last pixel of the last line, never on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_tick <= 1'b0;
         r_frame_cnt  <= 16'd0;
      end else begin
         r_frame_tick <= w_h_wrap && w_v_wrap;
         if (w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign frame_tick = r_frame_tick;
   assign frame_cnt  = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: default geometry for reset/line checks, small inverted-polarity geometry for frame checks
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_if vif_d ();
   vga_if vif_s ();

`ifdef VGA_FRAME_CNT_EN
   logic        ft_d, ft_s;
   logic [15:0] fc_d, fc_s;
`endif

   vga_timing_gen dut_d (
      .clk        (clk),
      .rst        (rst),
`ifdef VGA_FRAME_CNT_EN
      .vga_out    (vif_d),
      .frame_tick (ft_d),
      .frame_cnt  (fc_d)
`else
      .vga_out    (vif_d)
`endif
   );

   // Small raster: H_TOTAL 32 (blank 16..31, sync 20..27), V_TOTAL 14 (blank 8..13, sync 9..10), active-low syncs.
   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) dut_s (
      .clk        (clk),
      .rst        (rst),
`ifdef VGA_FRAME_CNT_EN
      .vga_out    (vif_s),
      .frame_tick (ft_s),
      .frame_cnt  (fc_s)
`else
      .vga_out    (vif_s)
`endif
   );

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int cur_h(input bit sel);
      return sel ? int'(vif_s.hcount) : int'(vif_d.hcount);
   endfunction

   function automatic int cur_v(input bit sel);
      return sel ? int'(vif_s.vcount) : int'(vif_d.vcount);
   endfunction

   task automatic run_to(input bit sel, input int h, input int v, input int limit, input string tag);
      int n = 0;
      while (!(cur_h(sel) == h && cur_v(sel) == v) && n < limit) begin
         step();
         n++;
      end
      check(tag, (cur_h(sel) == h && cur_v(sel) == v), 1);
   endtask

   initial begin
      int hb, hs, first_hs, bad;
      int vb, vs, hsl, ticks, bad_ticks;

      // Reset held three cycles
      repeat (3) step();
      check("rst_d_hcount", vif_d.hcount, 0);
      check("rst_d_vcount", vif_d.vcount, 0);
      check("rst_d_hblnk",  vif_d.hblnk,  0);
      check("rst_d_vblnk",  vif_d.vblnk,  0);
      check("rst_d_hsync",  vif_d.hsync,  0);
      check("rst_d_vsync",  vif_d.vsync,  0);
      check("rst_s_hsync",  vif_s.hsync,  1);
      check("rst_s_vsync",  vif_s.vsync,  1);
`ifdef VGA_FRAME_CNT_EN
      check("rst_d_tick", ft_d, 0);
      check("rst_d_cnt",  fc_d, 0);
`endif

      // Release: first cycle shows hcount 1
      rst = 1'b0;
      step();
      check("rel_d_hcount", vif_d.hcount, 1);
      check("rel_d_vcount", vif_d.vcount, 0);
      check("rel_s_hcount", vif_s.hcount, 1);

      // Line wrap on the default geometry
      run_to(1'b0, 1055, 10, 20000, "reach_d_1055_10");
      check("d_1055_hblnk", vif_d.hblnk, 1);
      check("d_1055_hsync", vif_d.hsync, 0);
      step();
      check("wrap_d_hcount", vif_d.hcount, 0);
      check("wrap_d_vcount", vif_d.vcount, 11);
      check("wrap_d_hblnk",  vif_d.hblnk,  0);

      // One full line: blank/sync widths and placement
      hb = 0; hs = 0; first_hs = -1; bad = 0;
      for (int i = 0; i < 1056; i++) begin
         if (vif_d.hblnk) hb++;
         if (vif_d.hsync) begin
            hs++;
            if (first_hs < 0) first_hs = int'(vif_d.hcount);
         end
         if (vif_d.hsync !== ((vif_d.hcount >= 840) && (vif_d.hcount < 968))) bad++;
         if (vif_d.hblnk !== (vif_d.hcount >= 800)) bad++;
         if (vif_d.vcount !== 11'd11) bad++;
         step();
      end
      check("line_hblnk_cycles", hb, 256);
      check("line_hsync_cycles", hs, 128);
      check("line_hsync_start",  first_hs, 840);
      check("line_decode_errs",  bad, 0);
      check("line_period_h", vif_d.hcount, 0);
      check("line_period_v", vif_d.vcount, 12);

      // Line-end corner into vertical blank (small geometry)
      run_to(1'b1, 31, 7, 500, "reach_s_31_7");
      check("s_31_7_vblnk", vif_s.vblnk, 0);
      check("s_31_7_hblnk", vif_s.hblnk, 1);
      step();
      check("corner_s_hcount", vif_s.hcount, 0);
      check("corner_s_vcount", vif_s.vcount, 8);
      check("corner_s_hblnk",  vif_s.hblnk,  0);
      check("corner_s_vblnk",  vif_s.vblnk,  1);

      // One full frame from (0,0)
      run_to(1'b1, 0, 0, 500, "reach_s_0_0");
      vb = 0; vs = 0; hsl = 0; bad = 0; ticks = 0;
      for (int i = 0; i < 448; i++) begin
         if (vif_s.vblnk) vb++;
         if (!vif_s.vsync) vs++;
         if (!vif_s.hsync) hsl++;
         if (vif_s.vsync !== !((vif_s.vcount >= 9) && (vif_s.vcount <= 10))) bad++;
         if (vif_s.hsync !== !((vif_s.hcount >= 20) && (vif_s.hcount <= 27))) bad++;
         if (vif_s.vblnk !== (vif_s.vcount >= 8)) bad++;
         if (vif_s.hblnk !== (vif_s.hcount >= 16)) bad++;
`ifdef VGA_FRAME_CNT_EN
         if (i > 0 && ft_s) ticks++;
`endif
         if (i < 447) step();
      end
      check("frame_vblnk_cycles", vb, 192);
      check("frame_vsync_cycles", vs, 64);
      check("frame_hsync_cycles", hsl, 112);
      check("frame_decode_errs",  bad, 0);
      check("frame_last_h", vif_s.hcount, 31);
      check("frame_last_v", vif_s.vcount, 13);
      step();
      check("frame_wrap_h", vif_s.hcount, 0);
      check("frame_wrap_v", vif_s.vcount, 0);
`ifdef VGA_FRAME_CNT_EN
      check("frame_no_early_tick", ticks, 0);
      check("frame_wrap_tick", ft_s, 1);
`endif

      // Mid-frame reset
      run_to(1'b1, 10, 5, 500, "reach_s_10_5");
      rst = 1'b1;
      step();
      check("mid_s_hcount", vif_s.hcount, 0);
      check("mid_s_vcount", vif_s.vcount, 0);
      check("mid_s_hblnk",  vif_s.hblnk,  0);
      check("mid_s_vblnk",  vif_s.vblnk,  0);
      check("mid_s_hsync",  vif_s.hsync,  1);
      check("mid_s_vsync",  vif_s.vsync,  1);
      check("mid_d_hcount", vif_d.hcount, 0);
      check("mid_d_vcount", vif_d.vcount, 0);
      check("mid_d_hsync",  vif_d.hsync,  0);
`ifdef VGA_FRAME_CNT_EN
      check("mid_s_tick", ft_s, 0);
      check("mid_s_cnt",  fc_s, 0);
`endif
      rst = 1'b0;
      step();
      check("restart_s_hcount", vif_s.hcount, 1);
      check("restart_s_vcount", vif_s.vcount, 0);
      check("restart_d_hcount", vif_d.hcount, 1);

`ifdef VGA_FRAME_CNT_EN
      // Three frames after reset: ticks only at the wrapped (0,0)
      check("post_rst_tick", ft_s, 0);
      ticks = 0; bad_ticks = 0;
      for (int i = 0; i < 1343; i++) begin
         step();
         if (ft_s) begin
            ticks++;
            if (vif_s.hcount !== 11'd0 || vif_s.vcount !== 11'd0) bad_ticks++;
         end
         if (ft_d) bad_ticks++;
      end
      check("three_frame_ticks", ticks, 3);
      check("tick_position_errs", bad_ticks, 0);
      check("three_frame_cnt", fc_s, 3);
      check("d_frame_cnt", fc_d, 0);
      check("end_s_hcount", vif_s.hcount, 0);
      check("end_s_vcount", vif_s.vcount, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator that drives the `vga_if` bundle (hcount, vcount, hblnk, vblnk, hsync, vsync) at the head of the display pipeline. Every downstream drawing stage consumes this bundle and re-registers it alongside its rgb output. All outputs are registered and mutually aligned, so a given hcount/vcount pair always appears in the same cycle as its blank and sync levels. Default geometry is 800x600 @ 60 Hz on a 40 MHz pixel clock.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, active level of hsync (1 = active-high)
- VSYNC_POL, 1, active level of vsync

Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- vga_out  vga_if.out  —  hcount [10:0], vcount [10:0], hblnk, vblnk, hsync, vsync
- frame_tick  out  1  one-cycle pulse at start of each frame (only with VGA_FRAME_CNT_EN)
- frame_cnt  out  16  frames completed since reset (only with VGA_FRAME_CNT_EN)

## Operation
- Horizontal counter h:
  - Increments by 1 every clk.
  - At H_TOTAL-1, wraps to 0 and advances the vertical counter v.
- Vertical counter v:
  - Wraps from V_TOTAL-1 to 0 on the same edge that h wraps.
  - Holds while h is not wrapping.
- Decode of the next-state counter values, registered together with the counts:
  - hblnk = 1 when H_ACTIVE ≤ hcount ≤ H_TOTAL-1 (800..1055).
  - hsync = HSYNC_POL when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (840..967); otherwise ~HSYNC_POL.
  - vblnk = 1 when V_ACTIVE ≤ vcount ≤ V_TOTAL-1 (600..627).
  - vsync = VSYNC_POL when V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (601..604); otherwise ~VSYNC_POL.
- Arithmetic:
  - Counters are 11 bit unsigned.
  - Parameter totals must be ≤ 2048; this is checked with an elaboration-time assertion.
- Generator has no input handshake; it never stalls.

## Timing
- Reset values (cycle after rst sampled high):
  - hcount = 0, vcount = 0, hblnk = 0, vblnk = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - frame_tick = 0, frame_cnt = 0
- First cycle with rst low: outputs show hcount = 1, vcount = 0.
- Latency: counts and their decoded blank/sync levels change on the same clk edge (zero skew between fields).
- Line period is H_TOTAL cycles; frame period is H_TOTAL*V_TOTAL = 663,168 cycles.
- Line-end corner: at (hcount = 1055, vcount = 599) the next cycle shows (0, 600) with hblnk = 0, vblnk = 1.
- Rst asserted mid-frame returns all outputs to reset values on the next edge, regardless of current position.

## Configuration
- VGA_FRAME_CNT_EN defined:
  - frame_tick and frame_cnt are present.
  - frame_tick = 1 for exactly the cycle whose outputs show (0, 0) following a wrap from (1055, 627). It is not asserted for the post-reset (0, 0).
  - frame_cnt increments on that same edge and wraps at 65535 → 0.
- VGA_FRAME_CNT_EN undefined: both ports and their registers are absent; the rest of the behaviour is identical.

## Test plan
- Reset release: hold rst for 3 cycles, then release -> (0, 0) during reset with syncs inactive; next cycle hcount = 1.
- Line wrap: run to hcount = 1055, vcount = 10 -> next cycle hcount = 0, vcount = 11; hblnk high for exactly 256 cycles per line; hsync active for exactly 128 cycles starting at hcount = 840.
- Frame wrap: run one full frame -> vcount 627 → 0 after 663,168 cycles; vblnk high for 28 lines; vsync active only for vcount 601..604.
- Mid-frame reset: assert rst at hcount = 500, vcount = 300 -> next cycle all outputs at reset values; counting restarts from 0.
- VGA_FRAME_CNT_EN: run 3 frames -> frame_tick pulses exactly 3 times, each coincident with (0, 0), none after reset; frame_cnt = 3.
- Polarity: HSYNC_POL = 0, VSYNC_POL = 0 -> hsync low only for hcount 840..967; vsync low only for vcount 601..604; high at reset.
